// File: rtl/jt12_slot_ctl.sv
// jt12_slot_ctl
// Slot sequencer and write arbiter for a recirculating per-slot delay line.
// The external delay line is STAGES deep and WIDTH wide, and advances on clk_en.
// This block owns the slot counter and closes the delay line into a loop. It
// zero-fills the loop after reset. It then injects one CPU-side parameter write
// into the target slot's time position and leaves every other slot untouched.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   clk_en           slot advance enable (shared with the delay line)
//   wr_req           write request level, held until wr_ack
//   wr_slot/wr_data  target slot and value
//   wr_ack/wr_err    one-clk completion pulse, error when wr_slot >= STAGES
//   sh_dout          delay-line output (stored value of the current slot)
//   sh_din           delay-line input (combinational)
//   slot/op/ch/zero  current slot, slot/6, slot%6, slot==0
//   init_done        loop contents valid
module jt12_slot_ctl #(
    parameter int STAGES = 24,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             wr_req,
    input  logic [4:0]       wr_slot,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    output logic             wr_err,
    input  logic [WIDTH-1:0] sh_dout,
    output logic [WIDTH-1:0] sh_din,
    output logic [4:0]       slot,
    output logic [1:0]       op,
    output logic [2:0]       ch,
    output logic             zero,
    output logic             init_done
);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, DONE} state_t;

    localparam logic [4:0] LAST_SLOT = 5'(STAGES - 1);
    localparam logic [5:0] NUM_SLOTS = 6'(STAGES);
    localparam logic [5:0] INIT_LAST = 6'(STAGES - 1);

    state_t           state_q, state_d;
    logic [4:0]       slot_q, slot_d;
    logic [5:0]       init_cnt_q, init_cnt_d;
    logic             init_done_q, init_done_d;
    logic [4:0]       lat_slot_q, lat_slot_d;
    logic [WIDTH-1:0] lat_data_q, lat_data_d;
    logic             wr_ack_q, wr_ack_d;
    logic             wr_err_q, wr_err_d;
    logic             slot_match;

    assign slot_match = (slot_q == lat_slot_q);

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        lat_slot_d  = lat_slot_q;
        lat_data_d  = lat_data_q;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;

        if (clk_en) begin
            slot_d = (slot_q == LAST_SLOT) ? 5'd0 : slot_q + 5'd1;
        end

        case (state_q)
            INIT: begin
                // One full revolution of zeros clears whatever the line held.
                if (clk_en) begin
                    init_cnt_d = init_cnt_q + 6'd1;
                    if (init_cnt_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            IDLE: begin
                // Acceptance is per clk, independent of clk_en. The wr_ack_q term
                // blocks re-acceptance of a request that has just been acked.
                if (wr_req && !wr_ack_q) begin
                    if ({1'b0, wr_slot} >= NUM_SLOTS) begin
                        wr_ack_d = 1'b1;
                        wr_err_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        lat_slot_d = wr_slot;
                        lat_data_d = wr_data;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                // Completes only on an enable edge. On that edge the delay line
                // takes the injected value.
                if (clk_en && slot_match) begin
                    wr_ack_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            slot_q      <= 5'd0;
            init_cnt_q  <= 6'd0;
            init_done_q <= 1'b0;
            lat_slot_q  <= 5'd0;
            lat_data_q  <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            lat_slot_q  <= lat_slot_d;
            lat_data_q  <= lat_data_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Loop closure: zero-fill while initialising, then recirculate. While a
    // write is pending, the latched value replaces the target slot's data.
    always_comb begin
        sh_din = sh_dout;
        if (state_q == INIT) begin
            sh_din = '0;
        end else if (state_q == WAIT && slot_match) begin
            sh_din = lat_data_q;
        end
    end

    assign slot      = slot_q;
    assign op        = 2'(slot_q / 5'd6);
    assign ch        = 3'(slot_q % 5'd6);
    assign zero      = (slot_q == 5'd0);
    assign init_done = init_done_q;
    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_jt12_slot_ctl.sv
// Testbench for jt12_slot_ctl: models the 24-deep delay line and uses a
// scoreboard queue of expected write acknowledgements.
module tb_jt12_slot_ctl;

    localparam int STAGES = 24;
    localparam int WIDTH  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_en = 1'b0;
    logic             wr_req = 1'b0;
    logic [4:0]       wr_slot = 5'd0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_ack, wr_err, zero, init_done;
    logic [WIDTH-1:0] sh_dout, sh_din;
    logic [4:0]       slot;
    logic [1:0]       op;
    logic [2:0]       ch;

    jt12_slot_ctl #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .sh_dout(sh_dout), .sh_din(sh_din),
        .slot(slot), .op(op), .ch(ch), .zero(zero), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // External delay line, starts with junk so zero-fill is observable.
    logic [WIDTH-1:0] line [STAGES];
    initial for (int i = 0; i < STAGES; i++) line[i] = 8'h5A;
    always @(posedge clk) begin
        if (clk_en) begin
            for (int i = STAGES - 1; i > 0; i--) line[i] <= line[i-1];
            line[0] <= sh_din;
        end
    end
    assign sh_dout = line[STAGES-1];

    // Reference slot counter and enable counter.
    int ref_slot = 0;
    int en_count = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_slot <= 0;
            en_count <= 0;
        end else if (clk_en) begin
            ref_slot <= (ref_slot == STAGES - 1) ? 0 : ref_slot + 1;
            en_count <= en_count + 1;
        end
    end

    // clk_en generator: en_div 0 = off, N = one enable every N clocks.
    int en_div = 0;
    int en_ph  = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (en_div == 0) begin
            clk_en = 1'b0;
        end else begin
            clk_en = (en_ph == 0);
            en_ph  = (en_ph + 1) % en_div;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot decode follows the reference counter at every cycle.
    logic [10:0] dec_act, dec_exp;
    always @(negedge clk) begin
        dec_act = {slot, op, ch, zero};
        dec_exp = {5'(ref_slot), 2'(ref_slot / 6), 3'(ref_slot % 6), (ref_slot == 0)};
        chk("slot_decode", {21'd0, dec_act}, {21'd0, dec_exp});
    end

    // Scoreboard: expected acks, popped by the monitor.
    typedef struct {
        logic err;
        int   slot;
    } ack_t;
    ack_t exp_q[$];
    ack_t mon_e;

    always @(negedge clk) begin
        if (wr_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got wr_ack=1 err=%0b expected no ack at %0t", wr_err, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_err", {31'd0, wr_err}, {31'd0, mon_e.err});
                chk("ack_slot", ref_slot, mon_e.slot);
            end
        end
    end

    logic [WIDTH-1:0] exp_mem [STAGES];

    task automatic push(input logic err, input int s);
        ack_t e;
        e.err  = err;
        e.slot = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input string name, input int exp_cycles);
        int n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (wr_ack === 1'b1) break;
            if (n > 400) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got no wr_ack after %0d clks required ack", name, n);
                break;
            end
        end
        chk({name, "_latency"}, n, exp_cycles);
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ref_slot == s && clk_en) && n < 500);
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL wait_slot_timeout: got no slot %0d required one", s);
        end
    endtask

    task automatic do_write(input int s, input int d, input logic err, input int ack_slot,
                            input int cycles, input string name);
        wr_slot = 5'(s);
        wr_data = 8'(d);
        wr_req  = 1'b1;
        push(err, ack_slot);
        wait_ack(name, cycles);
        wr_req  = 1'b0;
    endtask

    task automatic wait_enables(input int target);
        int n = 0;
        while (en_count < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (en_count < target) begin
            total++;
            bad++;
            $display("FAIL enable_timeout: got %0d enables required %0d", en_count, target);
        end
    endtask

    // One full revolution of readback against the expected slot contents.
    task automatic check_rev(input string name);
        int n = 0;
        int z = 0;
        int guard = 0;
        while (n < STAGES && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (clk_en) begin
                chk(name, {24'd0, sh_dout}, {24'd0, exp_mem[ref_slot]});
                if (zero) z++;
                n++;
            end
        end
        if (n < STAGES) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d enables required %0d", name, n, STAGES);
        end
        chk({name, "_zero_cnt"}, z, 1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_slot"}, {27'd0, slot}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd1);
        chk({tag, "_ack"}, {31'd0, wr_ack}, 32'd0);
        chk({tag, "_err"}, {31'd0, wr_err}, 32'd0);
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
        chk({tag, "_sh_din"}, {24'd0, sh_din}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < STAGES; i++) exp_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;

        // Zero-fill; a request during INIT must be ignored
        wr_slot = 5'd30;
        wr_data = 8'hFF;
        wr_req  = 1'b1;
        en_div  = 1;
        wait_enables(23);
        wr_req = 1'b0;
        chk("init_done_at_23", {31'd0, init_done}, 32'd0);
        chk("init_sh_din", {24'd0, sh_din}, 32'd0);
        @(negedge clk);
        chk("init_done_at_24", {31'd0, init_done}, 32'd1);
        check_rev("init_zero");

        // Valid write, slot 5 requested while slot 2
        wait_slot(2);
        do_write(5, 'hA5, 1'b0, 6, 4, "wr5");
        exp_mem[5] = 8'hA5;
        check_rev("wr5_rb");

        // Out-of-range slot
        wait_slot(10);
        do_write(30, 'h99, 1'b1, 11, 1, "wr30");
        check_rev("wr30_rb");

        // Sparse enables, slot 23 accepted on its own enable edge
        en_div = 3;
        wait_slot(23);
        do_write(23, 'h3C, 1'b0, 0, 73, "wr23");
        exp_mem[23] = 8'h3C;
        check_rev("wr23_rb");

        // Back-to-back writes with wr_req held across wr_ack
        en_div = 1;
        wait_slot(20);
        wr_slot = 5'd0;
        wr_data = 8'h11;
        wr_req  = 1'b1;
        push(1'b0, 1);
        wait_ack("b2b_0", 5);
        wr_slot = 5'd1;
        wr_data = 8'h22;
        push(1'b0, 2);
        wait_ack("b2b_1", 25);
        wr_req = 1'b0;
        exp_mem[0] = 8'h11;
        exp_mem[1] = 8'h22;
        check_rev("b2b_rb");

        // Reset while a write waits
        wait_slot(10);
        wr_slot = 5'd7;
        wr_data = 8'h77;
        wr_req  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n  = 1'b0;
        wr_req = 1'b0;
        #1;
        reset_checks("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < STAGES; i++) exp_mem[i] = 8'h00;
        wait_enables(24);
        chk("midrst_init_done", {31'd0, init_done}, 32'd1);
        check_rev("midrst_rb");
        repeat (30) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
